dmem_wait_responder: RTL and testbench

Data-memory responder for the 5-stage pipelined CPU: it receives the memRead/memWrite/address/writeData requests the EX/MEM stage drives and returns readData plus a stall signal. It models a word-addressed data RAM with a configurable number of wait states, so the pipeline's MEM stage can be exercised against a multi-cycle memory. With zero wait states it is cycle-equivalent to the existing single-cycle data memory.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/dmem_wait_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_wait_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_wait_responder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data-memory blocks.
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmemState_e;

  // Index width for a power-of-two depth; returns at least 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// EX/MEM to data-memory request/response bundle.
// The misaligned flag exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_wait_responder_if;
  import cpu_mem_pkg::*;

  logic              memRead;
  logic              memWrite;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] writeData;
  logic [WORD_W-1:0] readData;
  logic              stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              misaligned;

  modport master (output memRead, memWrite, address, writeData,
                  input  readData, stall, misaligned);
  modport slave  (input  memRead, memWrite, address, writeData,
                  output readData, stall, misaligned);
`else
  modport master (output memRead, memWrite, address, writeData,
                  input  readData, stall);
  modport slave  (input  memRead, memWrite, address, writeData,
                  output readData, stall);
`endif

endinterface

// File: rtl/dmem_array.sv
// Word storage: asynchronous clear, combinational read, one synchronous write port.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned IDX_W = clog2(DEPTH_WORDS)
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              writeEn,
  input  logic [IDX_W-1:0]  writeIdx,
  input  logic [WORD_W-1:0] writeData,
  input  logic [IDX_W-1:0]  readIdx,
  output logic [WORD_W-1:0] readData
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (writeEn) begin
      mem[writeIdx] <= writeData;
    end
  end

  assign readData = mem[readIdx];

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with WAIT_CYCLES wait states per access.
// Optional DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module dmem_wait_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                  clock_in,
  input logic                  reset,
  dmem_wait_responder_if.slave bus
);

  localparam int unsigned IDX_W = clog2(DEPTH_WORDS);

  dmemState_e        stateQ, stateD;
  logic [3:0]        cntQ, cntD;
  logic              latRead, latWrite;
  logic [IDX_W-1:0]  latIdx;
  logic [WORD_W-1:0] latData;

  logic              req;
  logic [IDX_W-1:0]  liveIdx;
  logic              complete, stall;
  logic              compRead, compWrite;
  logic [IDX_W-1:0]  compIdx;
  logic [WORD_W-1:0] compData;
  logic              misHit;
  logic [WORD_W-1:0] arrayData;

  assign req     = bus.memRead | bus.memWrite;
  assign liveIdx = bus.address[IDX_W+1:2];

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (req && WAIT_CYCLES != 0) begin
          if (WAIT_CYCLES == 1) begin
            stateD = DONE;
          end else begin
            stateD = WAIT;
            cntD   = 4'(WAIT_CYCLES - 32'd2);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          stateD = IDLE;
          cntD   = '0;
        end else if (cntQ == 4'd0) begin
          stateD = DONE;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Latches load only from IDLE; later input changes are ignored until DONE.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      latRead  <= 1'b0;
      latWrite <= 1'b0;
      latIdx   <= '0;
      latData  <= '0;
    end else if (stateQ == IDLE && req) begin
      latRead  <= bus.memRead;
      latWrite <= bus.memWrite;
      latIdx   <= liveIdx;
      latData  <= bus.writeData;
    end
  end

  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) complete = 1'b1;
          else                  stall    = 1'b1;
        end
      end
      WAIT:    stall    = 1'b1;
      DONE:    complete = 1'b1;
      default: stall    = 1'b0;
    endcase
  end

  assign compRead  = (stateQ == DONE) ? latRead  : bus.memRead;
  assign compWrite = (stateQ == DONE) ? latWrite : bus.memWrite;
  assign compIdx   = (stateQ == DONE) ? latIdx   : liveIdx;
  assign compData  = (stateQ == DONE) ? latData  : bus.writeData;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] latLow;
  logic       unusedAddr;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)                     latLow <= '0;
    else if (stateQ == IDLE && req) latLow <= bus.address[1:0];
  end

  assign misHit         = ((stateQ == DONE) ? latLow : bus.address[1:0]) != 2'b00;
  assign bus.misaligned = complete && misHit && !reset;
  assign unusedAddr     = ^bus.address[WORD_W-1:IDX_W+2];
`else
  logic unusedAddr;

  assign misHit     = 1'b0;
  assign unusedAddr = ^{bus.address[WORD_W-1:IDX_W+2], bus.address[1:0]};
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock_in  (clock_in),
    .reset     (reset),
    .writeEn   (complete && compWrite && !misHit),
    .writeIdx  (compIdx),
    .writeData (compData),
    .readIdx   (compIdx),
    .readData  (arrayData)
  );

  // Outputs drop with reset even while a request is still presented.
  assign bus.stall    = stall && !reset;
  assign bus.readData = (complete && compRead && !misHit && !reset) ? arrayData : '0;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder at 0, 2 and 3 wait states.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dmem_wait_responder_if bus0 ();
  dmem_wait_responder_if bus2 ();
  dmem_wait_responder_if bus3 ();

  assign bus0.memRead = rd;  assign bus0.memWrite = wr;
  assign bus0.address = addr; assign bus0.writeData = wdata;
  assign bus2.memRead = rd;  assign bus2.memWrite = wr;
  assign bus2.address = addr; assign bus2.writeData = wdata;
  assign bus3.memRead = rd;  assign bus3.memWrite = wr;
  assign bus3.address = addr; assign bus3.writeData = wdata;

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clock_in (clk), .reset (rst), .bus (bus0)
  );
  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut2 (
    .clock_in (clk), .reset (rst), .bus (bus2)
  );
  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_dut3 (
    .clock_in (clk), .reset (rst), .bus (bus3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's request at the falling edge; outputs are sampled before the rising edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    #2;
    checkVal("rst_stall", {31'd0, bus2.stall}, 32'd0);
    checkVal("rst_rdata", bus2.readData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One N=2 access: checks the 1,1,0 stall pattern and completion data.
  task automatic access2(input string tag, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] expRd);
    step(r, w, a, d);
    checkVal({tag, "_s0"}, {31'd0, bus2.stall}, 32'd1);
    checkVal({tag, "_d0"}, bus2.readData, 32'd0);
    step(r, w, a, d);
    checkVal({tag, "_s1"}, {31'd0, bus2.stall}, 32'd1);
    step(r, w, a, d);
    checkVal({tag, "_s2"}, {31'd0, bus2.stall}, 32'd0);
    checkVal({tag, "_rd"}, bus2.readData, expRd);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    checkVal("async_rst_stall", {31'd0, bus2.stall}, 32'd0);
    doReset();

    // Two wait states.
    access2("rd_fresh", 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    checkVal("idle_stall", {31'd0, bus2.stall}, 32'd0);
    checkVal("idle_rdata", bus2.readData, 32'd0);
    access2("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    access2("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    // Address changes after the first cycle must not affect the access.
    step(1'b1, 1'b0, 32'h10, 32'h0);
    checkVal("latch_s0", {31'd0, bus2.stall}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    checkVal("latch_rd", bus2.readData, 32'hDEADBEEF);
    access2("wr_wrap", 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0);
    access2("rd_wrap", 1'b1, 1'b0, 32'h000, 32'h0, 32'hA5A5A5A5);
    access2("rmw", 1'b1, 1'b1, 32'h000, 32'h1, 32'hA5A5A5A5);
    access2("rd_after_rmw", 1'b1, 1'b0, 32'h000, 32'h0, 32'h1);
    access2("rd_10_again", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Reset in the middle of a write: stall drops at once and memory clears.
    step(1'b0, 1'b1, 32'h10, 32'h55555555);
    checkVal("mid_s0", {31'd0, bus2.stall}, 32'd1);
    step(1'b0, 1'b1, 32'h10, 32'h55555555);
    rst = 1'b1;
    #1;
    checkVal("mid_rst_stall", {31'd0, bus2.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    access2("rd_cleared_10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
    access2("rd_cleared_0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    doReset();
    step(1'b0, 1'b1, 32'h6, 32'hCAFEF00D);
    checkVal("mis_s0", {31'd0, bus2.misaligned}, 32'd0);
    step(1'b0, 1'b1, 32'h6, 32'hCAFEF00D);
    step(1'b0, 1'b1, 32'h6, 32'hCAFEF00D);
    checkVal("mis_done", {31'd0, bus2.misaligned}, 32'd1);
    access2("mis_unchanged", 1'b1, 1'b0, 32'h4, 32'h0, 32'h0);
    checkVal("mis_aligned", {31'd0, bus2.misaligned}, 32'd0);
`endif

    // Zero wait states: single-cycle behaviour.
    doReset();
    step(1'b0, 1'b1, 32'h4, 32'h12345678);
    checkVal("n0_wr_stall", {31'd0, bus0.stall}, 32'd0);
    step(1'b1, 1'b0, 32'h4, 32'h0);
    checkVal("n0_rd_stall", {31'd0, bus0.stall}, 32'd0);
    checkVal("n0_rd", bus0.readData, 32'h12345678);
    step(1'b1, 1'b1, 32'h4, 32'h9);
    checkVal("n0_rmw", bus0.readData, 32'h12345678);
    step(1'b1, 1'b0, 32'h4, 32'h0);
    checkVal("n0_rd_new", bus0.readData, 32'h9);
    step(1'b0, 1'b0, 32'h4, 32'h0);
    checkVal("n0_idle", bus0.readData, 32'h0);

    // Three wait states with an abort in the second WAIT cycle.
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h8, 32'h11111111);
      checkVal("n3_wr_stall", {31'd0, bus3.stall}, (i < 3) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b1, 32'h8, 32'h22222222);
    step(1'b0, 1'b1, 32'h8, 32'h22222222);
    step(1'b0, 1'b0, 32'h8, 32'h22222222);
    checkVal("n3_abort_stall", {31'd0, bus3.stall}, 32'd1);
    step(1'b0, 1'b0, 32'h8, 32'h0);
    checkVal("n3_idle_stall", {31'd0, bus3.stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h8, 32'h0);
      checkVal("n3_rd_stall", {31'd0, bus3.stall}, (i < 3) ? 32'd1 : 32'd0);
      checkVal("n3_rd_data", bus3.readData, (i < 3) ? 32'h0 : 32'h11111111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
